// File: rtl/seq_sched_if.sv
// Requester/consumer bundle for seq_sched: request words in, tagged results out.
// Master modport is the requester fabric side; slave modport is the scheduler.
interface seq_sched_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(W + 1);

    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;

    // Result handshake: a result transfers on a clock edge where res_valid && res_ready.
    // Once raised, res_valid and res_id/res_cnt/res_first stay stable until that edge.
    logic           res_valid;
    logic           res_ready;
    logic [IW-1:0]  res_id;
    logic [CW-1:0]  res_cnt;
    logic [CW-1:0]  res_first;

    modport master (
        output req, req_data, res_ready,
        input  gnt, res_valid, res_id, res_cnt, res_first
    );

    modport slave (
        input  req, req_data, res_ready,
        output gnt, res_valid, res_id, res_cnt, res_first
    );
endinterface

// File: rtl/seq_sched.sv
// Round-robin scheduler sharing one serial sequence detector among N requesters.
// Optional first-hit index tracking is enabled by defining SEQ_SCHED_FIRST_HIT_EN.
module seq_sched #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int DET_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_sched_if.slave  bus,
    output logic        det_rst_n,
    output logic        det_seq_in,
    input  logic        det_seq_out,
    output logic [2:0]  state_dbg
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [1:0]    lat_q, lat_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          det_rst_n_q, det_rst_n_d;
    logic          det_seq_in_q, det_seq_in_d;
`ifdef SEQ_SCHED_FIRST_HIT_EN
    logic [CW-1:0] first_q, first_d;
`endif

    logic          win_found;
    logic [IW-1:0] win_id;
    logic [W-1:0]  win_word;
    logic [IW:0]   cand;
    logic [IW:0]   ptr_inc;
    logic [N-1:0]  gnt_c;

    // Search upward from ptr_q, wrapping at N; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_word  = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!win_found && bus.req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IW-1:0];
                win_word  = bus.req_data[int'(cand)*W +: W];
            end
        end
        ptr_inc = {1'b0, win_id} + (IW+1)'(1);
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        sh_d         = sh_q;
        bit_d        = bit_q;
        lat_d        = lat_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
        first_d      = first_q;
`endif
        gnt_c        = '0;
        det_rst_n_d  = 1'b1;
        det_seq_in_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_c[win_id] = 1'b1;
                    ptr_d         = (ptr_inc == (IW+1)'(N)) ? '0 : ptr_inc[IW-1:0];
                    id_d          = win_id;
                    sh_d          = win_word;
                    state_d       = CLEAR;
                end
            end
            CLEAR: begin
                bit_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
                lat_d   = 2'(DET_LAT);
`ifdef SEQ_SCHED_FIRST_HIT_EN
                first_d = '1;
`endif
                state_d = SHIFT;
            end
            SHIFT, DRAIN: begin
                // lat_q skips the first DET_LAT cycles so each sample lines up with its bit.
                if (lat_q != 2'd0) begin
                    lat_d = lat_q - 2'd1;
                end else begin
                    idx_d = idx_q + CW'(1);
                    if (det_seq_out) begin
                        cnt_d = cnt_q + CW'(1);
`ifdef SEQ_SCHED_FIRST_HIT_EN
                        if (cnt_q == '0) begin
                            first_d = idx_q;
                        end
`endif
                    end
                end
                if (state_q == SHIFT) begin
                    sh_d  = sh_q << 1;
                    bit_d = bit_q + CW'(1);
                    if (bit_q == CW'(W - 1)) begin
                        state_d = (DET_LAT == 0) ? DONE : DRAIN;
                    end
                end else if (lat_q == 2'd0 && idx_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Detector pins are registered, so they are computed from the next state.
        det_rst_n_d = (state_d != CLEAR);
        if (state_d == SHIFT) begin
            det_seq_in_d = sh_d[W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            sh_q         <= '0;
            bit_q        <= '0;
            lat_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            det_rst_n_q  <= 1'b0;
            det_seq_in_q <= 1'b0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
            first_q      <= '1;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            sh_q         <= sh_d;
            bit_q        <= bit_d;
            lat_q        <= lat_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            det_rst_n_q  <= det_rst_n_d;
            det_seq_in_q <= det_seq_in_d;
`ifdef SEQ_SCHED_FIRST_HIT_EN
            first_q      <= first_d;
`endif
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_id    = id_q;
    assign bus.res_cnt   = cnt_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
    assign bus.res_first = first_q;
`else
    assign bus.res_first = '1;
`endif
    assign det_rst_n     = det_rst_n_q;
    assign det_seq_in    = det_seq_in_q;
    assign state_dbg     = state_q;
endmodule

// File: doc/seq_sched.md
# seq_sched

Round-robin scheduler that shares one serial sequence detector (`seq`: `clk`, `rst_n`, `seq_in`, `seq_out`) among N requesters. Each requester submits a W-bit word. The block grants one word at a time and clears the detector through its reset. It then shifts the word MSB-first into `seq_in`, counts `seq_out` pulses over the aligned window, and returns a tagged result through a valid/ready port. It sits between the requester fabric and the single `u_seq` instance.

## Interface
- `N`, 4: number of requesters, 2..8.
- `W`, 8: word width in bits, 2..32.
- `DET_LAT`, 1: cycles from a bit appearing on `seq_in` to its `seq_out` response, 0..3.
- `CW` (localparam), $clog2(W+1): width of the count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N: per-requester request; held together with its data until granted.
- `req_data` in N*W: flattened words; requester i occupies bits [i*W +: W].
- `gnt` out N: one-hot grant; high only during the capture cycle.
- `det_rst_n` out 1: registered, active-low clear to the detector's `rst_n`.
- `det_seq_in` out 1: registered serial bit to the detector's `seq_in`.
- `det_seq_out` in 1: detector's `seq_out`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out $clog2(N): index of the granted requester.
- `res_cnt` out CW: number of detections in the frame.
- `res_first` out CW: bit index (0 = MSB) of the first detection; all-ones if there was none.

## Operation
- FSM states are IDLE, CLEAR, SHIFT, DRAIN and DONE. Reset state is IDLE.
- **IDLE**
  - If any `req` is set, grant the first set bit searching upward from `ptr` (wrapping at N).
  - `gnt` is combinational for that cycle only.
  - Capture the word and the id, set `ptr` = winner+1 mod N, then go to CLEAR.
  - `ptr` resets to 0.
- **CLEAR**: lasts 1 cycle with `det_rst_n`=0 and `det_seq_in`=0. The frame counters are cleared. Go to SHIFT.
- **SHIFT**
  - Lasts W cycles. In cycle k (k=0..W-1), `det_seq_in` = word[W-1-k].
  - Go to DRAIN after cycle W-1; if DET_LAT=0, go directly to DONE.
- **DRAIN**: lasts DET_LAT cycles with `det_seq_in`=0. Then go to DONE.
- **Counting window**
  - Number the cycles c from the first SHIFT cycle (c=0). `det_seq_out` is sampled in cycles c=DET_LAT..W-1+DET_LAT only.
  - Each sampled 1 increments `res_cnt`. A sample at cycle c belongs to bit index c-DET_LAT.
  - `det_seq_out` outside the window is ignored.
- **DONE**
  - `res_valid`=1, and `res_id`/`res_cnt`/`res_first` are held stable.
  - On `res_valid && res_ready`, go to IDLE.
  - No grant is issued in the DONE cycle.
- `res_cnt` cannot overflow, because at most W samples are counted.
- `req` dropping while not granted is legal and simply withdraws the request. Dropping after grant has no effect on the frame.
- **Reset mid-frame**: asynchronous return to IDLE. The frame is discarded and no result is produced.

## Timing
- Reset values:
  - `gnt`=0, `det_rst_n`=0, `det_seq_in`=0.
  - `res_valid`=0, `res_id`=0, `res_cnt`=0, `res_first`=all-ones.
- `det_rst_n` rises on the first clock edge after `rst_n` deasserts.
- Latency: grant in cycle T, CLEAR in T+1, SHIFT in T+2..T+1+W, DRAIN until T+1+W+DET_LAT, `res_valid` from T+2+W+DET_LAT.
- Minimum frame period is W+DET_LAT+3 cycles, with `res_ready` tied high.
- While `res_valid` is high, further `req` assertions wait; no grants are issued.

## Configuration
- Macro: `SEQ_SCHED_FIRST_HIT_EN`.
- Defined: `res_first` records the bit index of the first counted detection and stays all-ones when `res_cnt`=0.
- Undefined: the first-hit register is removed and `res_first` is tied to all-ones. All other behaviour is identical.

## Test plan
Setup: N=4, W=8, DET_LAT=1, with a detector stub where `seq_out` = `seq_in` delayed by one cycle (counts 1s).

- Reset held, then released → all outputs at reset values; `det_rst_n` is 0 during reset and 1 after the first edge.
- `req`=0001, data0=8'hB6 → `gnt`=0001 for 1 cycle; `det_seq_in` = 1,0,1,1,0,1,1,0; `res_valid` 11 cycles after the grant with `res_id`=0, `res_cnt`=5, `res_first`=0.
- `req`=1111 held across frames with all data=8'h01 → grant order 0,1,2,3,0; each result has `res_cnt`=1 and `res_first`=7.
- data=8'h00 → `res_cnt`=0 and `res_first`=4'hF. Pulses on `det_seq_out` injected during CLEAR or IDLE are not counted.
- `res_ready` held low for 5 cycles in DONE → result stays stable and no `gnt` is issued; release → IDLE, then the next grant.
- `rst_n` pulsed low during SHIFT cycle 3 → immediate IDLE with outputs at reset values; no `res_valid`; the next request proceeds normally starting from `ptr`=0.
